// File: rtl/div_share_pkg.sv
// Shared definitions for the divider-sharing scheduler.
//   DIV_W          : operand / quotient width of the shared divider
//   ID_W           : requester-id width, sized for the largest supported NREQ (8)
//   tag_t          : per-issue owner tag carried alongside the divider pipeline
//   QUOT_ALL_ONES  : quotient returned for a flagged divide-by-zero
package div_share_pkg;

    localparam int DIV_W    = 64;
    localparam int MAX_NREQ = 8;
    localparam int ID_W     = $clog2(MAX_NREQ);

    localparam logic [DIV_W-1:0] QUOT_ALL_ONES = {DIV_W{1'b1}};

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            dbz;
    } tag_t;

    localparam tag_t TAG_IDLE = tag_t'({(ID_W+2){1'b0}});

    function automatic tag_t make_tag(input logic valid, input logic [ID_W-1:0] id,
                                      input logic dbz);
        tag_t t;
        t.valid = valid;
        t.id    = id;
        t.dbz   = dbz;
        return t;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The requester at index rr has the highest priority; the search proceeds
// upward modulo NREQ.
//   req       in  NREQ  request vector
//   rr        in  ID_W  highest-priority index (0..NREQ-1)
//   grant     out NREQ  one-hot grant, or zero when no request
//   grant_idx out ID_W  index of the granted requester (valid with grant_any)
//   grant_any out 1     some requester was granted
module rr_arbiter
    import div_share_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    localparam logic [ID_W:0]   NREQ_W   = (ID_W+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [ID_W:0]     off_s;
    logic [ID_W:0]     sum_s;
    logic              found_s;

    // Rotate the request vector so bit 0 is the rr requester, take the first
    // set bit, then map the offset back to an absolute index.
    always_comb begin
        dbl_s   = {req, req};
        rot_s   = NREQ'(dbl_s >> rr);
        found_s = 1'b0;
        off_s   = {(ID_W+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (rot_s[k] && !found_s) begin
                found_s = 1'b1;
                off_s   = (ID_W+1)'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, rr} + off_s;
        if (sum_s >= NREQ_W) begin
            grant_idx = ID_W'(sum_s - NREQ_W);
        end else begin
            grant_idx = ID_W'(sum_s);
        end
        grant_any = found_s;
        if (found_s) begin
            grant = ONE_HOT0 << grant_idx;
        end else begin
            grant = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one pipelined 64-bit divider between NREQ
// requesters. Each issue carries an owner tag through a pipeline matched to
// the divider latency so the quotient is routed back to its requester.
// Optional build macro: DIV_ZERO_CHECK_EN (flag divisor==0 at accept and
// force an all-ones quotient with rsp_dbz=1 on the response).
//   clk, rstn        clock, synchronous active-low reset
//   req_valid/ready  per-requester handshake (ready is the combinational grant)
//   req_dividend/divisor  packed operands, requester i at [64*i +: 64]
//   rsp_valid        one-cycle one-hot result strobe
//   rsp_quotient     result for the flagged requester
//   rsp_dbz          divide-by-zero flag (0 unless DIV_ZERO_CHECK_EN)
//   div_dividend/divisor/quotient  shared divider connection
//   busy             any issued divide still in flight
module div_share_sched
    import div_share_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DIV_LATENCY = 65
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*DIV_W-1:0] req_dividend,
    input  logic [NREQ*DIV_W-1:0] req_divisor,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [DIV_W-1:0]      rsp_quotient,
    output logic                  rsp_dbz,
    output logic [DIV_W-1:0]      div_dividend,
    output logic [DIV_W-1:0]      div_divisor,
    input  logic [DIV_W-1:0]      div_quotient,
    output logic                  busy
);

    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NREQ-1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0]  rr_r;
    logic [NREQ-1:0]  grant_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic             grant_any_s;
    logic [DIV_W-1:0] sel_dividend_s;
    logic [DIV_W-1:0] sel_divisor_s;
    logic             dbz_s;
    tag_t             new_tag_s;
    // Stage k lines up with the divider's input k cycles ago; the last stage
    // lines up with div_quotient.
    tag_t             tag_pipe_r [0:DIV_LATENCY];
    logic [DIV_W-1:0] div_dividend_r;
    logic [DIV_W-1:0] div_divisor_r;
    logic [NREQ-1:0]  rsp_valid_r;
    logic [DIV_W-1:0] rsp_quotient_r;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .rr        (rr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign req_ready    = grant_s;
    assign div_dividend = div_dividend_r;
    assign div_divisor  = div_divisor_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_quotient = rsp_quotient_r;

    // Select the granted requester's operands and build its tag.
    always_comb begin
        sel_dividend_s = {DIV_W{1'b0}};
        sel_divisor_s  = {DIV_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (grant_s[k]) begin
                sel_dividend_s = req_dividend[k*DIV_W +: DIV_W];
                sel_divisor_s  = req_divisor[k*DIV_W +: DIV_W];
            end else begin
                sel_dividend_s = sel_dividend_s;
            end
        end
`ifdef DIV_ZERO_CHECK_EN
        dbz_s = (sel_divisor_s == {DIV_W{1'b0}});
`else
        dbz_s = 1'b0;
`endif
        new_tag_s = make_tag(grant_any_s, grant_idx_s, dbz_s);
    end

    // Round-robin pointer: the requester after the winner gets top priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_r <= {ID_W{1'b0}};
        end else if (grant_any_s) begin
            rr_r <= (grant_idx_s == LAST_ID) ? {ID_W{1'b0}} : grant_idx_s + 1'b1;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Divider operand registers; they hold when nothing is issued.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_dividend_r <= {DIV_W{1'b0}};
            div_divisor_r  <= {DIV_W{1'b0}};
        end else if (grant_any_s) begin
            div_dividend_r <= sel_dividend_s;
            div_divisor_r  <= sel_divisor_s;
        end else begin
            div_dividend_r <= div_dividend_r;
            div_divisor_r  <= div_divisor_r;
        end
    end

    // Tag pipeline shifts every cycle; an idle slot pushes an invalid tag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k <= DIV_LATENCY; k++) begin
                tag_pipe_r[k] <= TAG_IDLE;
            end
        end else begin
            tag_pipe_r[0] <= new_tag_s;
            for (int k = 1; k <= DIV_LATENCY; k++) begin
                tag_pipe_r[k] <= tag_pipe_r[k-1];
            end
        end
    end

    // Response register: strobe the owner of the tag aligned with div_quotient.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid_r    <= {NREQ{1'b0}};
            rsp_quotient_r <= {DIV_W{1'b0}};
        end else if (tag_pipe_r[DIV_LATENCY].valid) begin
            rsp_valid_r <= ONE_HOT0 << tag_pipe_r[DIV_LATENCY].id;
`ifdef DIV_ZERO_CHECK_EN
            rsp_quotient_r <= tag_pipe_r[DIV_LATENCY].dbz ? QUOT_ALL_ONES : div_quotient;
`else
            rsp_quotient_r <= div_quotient;
`endif
        end else begin
            rsp_valid_r    <= {NREQ{1'b0}};
            rsp_quotient_r <= rsp_quotient_r;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic rsp_dbz_r;

    // Divide-by-zero flag travels with the response strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_dbz_r <= 1'b0;
        end else if (tag_pipe_r[DIV_LATENCY].valid) begin
            rsp_dbz_r <= tag_pipe_r[DIV_LATENCY].dbz;
        end else begin
            rsp_dbz_r <= 1'b0;
        end
    end

    assign rsp_dbz = rsp_dbz_r;
`else
    assign rsp_dbz = 1'b0;
`endif

    // Busy while any tag in flight is valid.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= DIV_LATENCY; k++) begin
            busy = busy | tag_pipe_r[k].valid;
        end
    end

endmodule

// File: tb/tb_div_share_sched.sv
// Self-checking bench for div_share_sched with a behavioural 65-stage divider.
// A negedge monitor models round-robin grants and keeps an in-order scoreboard
// of expected responses (owner, quotient, dbz flag, arrival cycle).
module tb_div_share_sched;

    localparam int NREQ = 4;
    localparam int L    = 65;
    localparam int W    = 64;
`ifdef DIV_ZERO_CHECK_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_quotient;
    logic              rsp_dbz;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic [W-1:0]      div_quotient;
    logic              busy;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    int rr_m   = 0;
    logic [NREQ-1:0] acc_mask = '0;

    typedef struct {
        int         id;
        logic [W-1:0] q;
        logic       dbz;
        int         due;
    } exp_t;
    exp_t sb_q[$];
    exp_t e_mon;

    div_share_sched #(.NREQ(NREQ), .DIV_LATENCY(L)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .rsp_dbz      (rsp_dbz),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 64'd0) return {W{1'b1}};
        return a / b;
    endfunction

    // Behavioural divider: operands in, quotient L cycles later.
    logic [W-1:0] q_pipe [L];
    assign div_quotient = q_pipe[L-1];
    always @(posedge clk) begin
        for (int k = L-1; k > 0; k--) q_pipe[k] <= q_pipe[k-1];
        q_pipe[0] <= model_div(div_dividend, div_divisor);
    end

    function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] req, input int rr);
        logic [NREQ-1:0] g;
        g = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr + k) % NREQ;
            if (req[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Monitor: score responses, check grants, push expectations on accepts.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [NREQ-1:0] exp_g;
            acc_mask = '0;
            if (rsp_valid !== '0) begin
                if (sb_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b at cycle %0d, none outstanding", rsp_valid, cyc);
                end else begin
                    logic [NREQ-1:0] exp_v;
                    e_mon = sb_q.pop_front();
                    exp_v = '0;
                    exp_v[e_mon.id] = 1'b1;
                    checks++;
                    if (rsp_valid !== exp_v) begin
                        errs++;
                        $display("FAIL rsp_owner: got %b expected %b", rsp_valid, exp_v);
                    end
                    checks++;
                    if (rsp_quotient !== e_mon.q) begin
                        errs++;
                        $display("FAIL rsp_quotient: got %h expected %h (req %0d)", rsp_quotient, e_mon.q, e_mon.id);
                    end
                    checks++;
                    if (rsp_dbz !== e_mon.dbz) begin
                        errs++;
                        $display("FAIL rsp_dbz: got %b expected %b", rsp_dbz, e_mon.dbz);
                    end
                    checks++;
                    if (cyc != e_mon.due) begin
                        errs++;
                        $display("FAIL rsp_timing: got cycle %0d expected %0d", cyc, e_mon.due);
                    end
                end
            end
            if (rstn === 1'b1) begin
                exp_g = rr_grant(req_valid, rr_m);
                checks++;
                if (req_ready !== exp_g) begin
                    errs++;
                    $display("FAIL grant: got %b expected %b (valid %b rr %0d)", req_ready, exp_g, req_valid, rr_m);
                end
                acc_mask = req_valid & req_ready;
                for (int i = 0; i < NREQ; i++) begin
                    if (acc_mask[i]) begin
                        exp_t e;
                        logic [W-1:0] a;
                        logic [W-1:0] b;
                        a = req_dividend[i*W +: W];
                        b = req_divisor[i*W +: W];
                        e.id  = i;
                        e.q   = model_div(a, b);
                        e.dbz = DBZ_EN && (b == 64'd0);
                        e.due = cyc + L + 2;
                        sb_q.push_back(e);
                        rr_m = (i + 1) % NREQ;
                    end
                end
            end else begin
                sb_q.delete();
                rr_m = 0;
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i] = 1'b1;
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
    endtask

    task automatic reset_dut();
        @(posedge clk) #1;
        rstn = 1'b0;
        @(posedge clk) #1;
        rstn = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (L + 5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d responses missing", sb_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL busy_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        for (int k = 0; k < L; k++) q_pipe[k] = '0;
        @(posedge clk) #1;
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_quotient !== 64'd0 || rsp_dbz !== 1'b0) begin
            errs++;
            $display("FAIL reset_rsp: got %b/%h/%b expected 0/0/0", rsp_valid, rsp_quotient, rsp_dbz);
        end
        checks++;
        if (div_dividend !== 64'd0 || div_divisor !== 64'd0) begin
            errs++;
            $display("FAIL reset_div: got %h/%h expected 0/0", div_dividend, div_divisor);
        end
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0000) begin
            errs++;
            $display("FAIL reset_busy: got busy=%b ready=%b expected 0/0000", busy, req_ready);
        end
        @(posedge clk) #1;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int t0;
        @(posedge clk) #1;
        set_req(2, 64'd100, 64'd7);
        @(negedge clk);
        t0 = cyc;
        checks++;
        if (req_ready !== 4'b0100) begin
            errs++;
            $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        @(posedge clk) #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (div_dividend !== 64'd100 || div_divisor !== 64'd7 || busy !== 1'b1) begin
            errs++;
            $display("FAIL single_issue: got %0d/%0d busy=%b expected 100/7 busy=1", div_dividend, div_divisor, busy);
        end
        while (cyc < t0 + L + 2) @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_quotient !== 64'd14) begin
            errs++;
            $display("FAIL single_rsp: got %b/%0d expected 0100/14", rsp_valid, rsp_quotient);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            errs++;
            $display("FAIL single_after: got %b busy=%b expected 0000 busy=0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_r;
        reset_dut();
        @(posedge clk) #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 64'd1000 + 64'(i * 77), 64'(i + 2));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_r = '0;
            exp_r[c % NREQ] = 1'b1;
            checks++;
            if (req_ready !== exp_r) begin
                errs++;
                $display("FAIL rr_seq: cycle %0d got %b expected %b", c, req_ready, exp_r);
            end
            @(posedge clk) #1;
            set_req(c % NREQ, 64'd5000 + 64'(c * 37), 64'(c + 3));
        end
        drain();
    endtask

    task automatic test_rr_skip();
        logic [NREQ-1:0] vals [5];
        logic [NREQ-1:0] exps [5];
        vals[0] = 4'b0001; exps[0] = 4'b0001;
        vals[1] = 4'b0010; exps[1] = 4'b0010;
        vals[2] = 4'b1010; exps[2] = 4'b1000;
        vals[3] = 4'b0010; exps[3] = 4'b0010;
        vals[4] = 4'b1111; exps[4] = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk) #1;
            req_valid = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (vals[c][i]) set_req(i, 64'd900 + 64'(c * 11 + i), 64'(i + 1));
            end
            @(negedge clk);
            checks++;
            if (req_ready !== exps[c]) begin
                errs++;
                $display("FAIL rr_skip: step %0d got %b expected %b", c, req_ready, exps[c]);
            end
        end
        drain();
    endtask

    task automatic test_dbz();
        int t0;
        @(posedge clk) #1;
        set_req(0, 64'd55, 64'd0);
        @(negedge clk);
        t0 = cyc;
        @(posedge clk) #1;
        set_req(0, 64'd55, 64'd5);
        @(posedge clk) #1;
        req_valid = '0;
        while (cyc < t0 + L + 2) @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_quotient !== {W{1'b1}} || rsp_dbz !== DBZ_EN) begin
            errs++;
            $display("FAIL dbz_zero: got %b/%h/%b expected 0001/all-ones/%b", rsp_valid, rsp_quotient, rsp_dbz, DBZ_EN);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_quotient !== 64'd11 || rsp_dbz !== 1'b0) begin
            errs++;
            $display("FAIL dbz_next: got %b/%0d/%b expected 0001/11/0", rsp_valid, rsp_quotient, rsp_dbz);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int stray;
        int t0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk) #1;
            req_valid = '0;
            set_req(c % NREQ, 64'd7000 + 64'(c * 13), 64'(c + 1));
        end
        @(posedge clk) #1;
        req_valid = '0;
        repeat (19) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk) #1;
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_quotient !== 64'd0 || rsp_dbz !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL midreset_rsp: got %b/%h/%b busy=%b expected 0000/0/0/0", rsp_valid, rsp_quotient, rsp_dbz, busy);
        end
        checks++;
        if (div_dividend !== 64'd0 || div_divisor !== 64'd0) begin
            errs++;
            $display("FAIL midreset_div: got %h/%h expected 0/0", div_dividend, div_divisor);
        end
        stray = 0;
        repeat (L + 10) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) stray++;
        end
        checks++;
        if (stray != 0) begin
            errs++;
            $display("FAIL midreset_stray: got %0d responses expected 0", stray);
        end
        @(posedge clk) #1;
        set_req(3, 64'd81, 64'd9);
        @(negedge clk);
        t0 = cyc;
        @(posedge clk) #1;
        req_valid = '0;
        while (cyc < t0 + L + 2) @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_quotient !== 64'd9) begin
            errs++;
            $display("FAIL midreset_new: got %b/%0d expected 1000/9", rsp_valid, rsp_quotient);
        end
        drain();
    endtask

    function automatic logic [W-1:0] rnd_b();
        int sel;
        sel = $urandom_range(7, 0);
        if (sel == 0) return 64'd0;
        if (sel <= 2) return 64'($urandom_range(16, 1));
        if (sel <= 4) return {32'd0, 32'($urandom)};
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic test_random(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk) #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && acc_mask[i]) begin
                    if ($urandom_range(1, 0) == 1) set_req(i, {32'($urandom), 32'($urandom)}, rnd_b());
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
                    set_req(i, {32'($urandom), 32'($urandom)}, rnd_b());
                end
            end
        end
        @(posedge clk) #1;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rr_skip();
        test_dbz();
        test_reset_mid();
        test_random(10000);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/div_share_sched.md
# div_share_sched

Round-robin scheduler that shares one fixed-latency 64-bit pipelined divider (clk/rstn/dividend/divisor/quotient, one issue per cycle) between NREQ requesters. Accepts valid/ready requests, issues at most one divide per cycle, tracks each issue's owner through a tag pipeline matched to the divider latency, and routes each quotient back to its requester. Sits between the rate/timing-calculation clients of the video/Ethernet path and the single divider instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- DIV_LATENCY, 65, cycles from divider operand input to valid quotient output; must equal the instantiated divider's pipeline depth
- clk  in  1  system clock, all logic rising-edge
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_dividend  in  NREQ*64  dividend, requester i at [64*i+63:64*i]
- req_divisor  in  NREQ*64  divisor, same packing
- rsp_valid  out  NREQ  one-cycle result strobe, one-hot or zero
- rsp_quotient  out  64  result for the requester flagged in rsp_valid
- rsp_dbz  out  1  divide-by-zero flag, qualified by rsp_valid (DIV_ZERO_CHECK_EN only; tied 0 otherwise)
- div_dividend  out  64  to divider
- div_divisor  out  64  to divider
- div_quotient  in  64  from divider
- busy  out  1  any issued divide not yet returned

## Operation
- Handshake per requester: transfer when req_valid[i] && req_ready[i]; requester holds valid and operands stable until accepted; valid must not drop before acceptance.
- Arbitration: combinational round-robin; pointer rr (0..NREQ-1) is highest priority, search ascending modulo NREQ. req_ready = grant, independent of rsp state (responses have no backpressure; clients must sink rsp_valid every cycle).
- On grant to i: rr <= (i+1) mod NREQ; register operands onto div_dividend/div_divisor; push tag {valid=1, id=i, dbz} into tag pipeline. No grant: rr unchanged, tag valid=0 pushed, div operands hold last value.
- Tag pipeline: DIV_LATENCY+1 stages, shifts every cycle. At output stage, if valid: rsp_valid[id] <= 1, rsp_quotient <= div_quotient (or dbz override), else rsp_valid <= 0, rsp_quotient holds.
- busy = OR of all tag valid bits.
- Operands are passed unmodified; signedness is the divider's.
- Reset (any time, including mid-operation): rr=0, all tags invalid, rsp_valid=0, rsp_quotient=0, rsp_dbz=0, div_dividend=0, div_divisor=0, busy=0 on next cycle. Divider pipeline contents still draining after reset return with invalid tags and are discarded.

## Timing
- Accept at cycle T -> operands at divider inputs T+1 -> quotient valid at divider T+1+DIV_LATENCY -> rsp_valid high at T+2+DIV_LATENCY for exactly one cycle.
- Throughput: one accept per cycle total; sustained fair share 1/NREQ per requester when all request.
- Back-to-back accepts return back-to-back responses in issue order.
- Simultaneous accept and response in one cycle: independent, both occur.
- req_ready asserted in the same cycle req_valid rises (zero-cycle grant when rr favours it or others idle).

## Configuration
- DIV_ZERO_CHECK_EN defined: divisor==0 detected at accept; tag carries dbz=1; response returns rsp_quotient=64'hFFFF_FFFF_FFFF_FFFF and rsp_dbz=1 regardless of divider output; divider still issued (slot consumed).
- Undefined: no detection, rsp_dbz tied 0, rsp_quotient is raw divider output.

## Structure
- Package div_share_pkg: DIV_W=64 constant, tag typedef {valid, id[$clog2(NREQ)], dbz}, all-ones quotient constant.
- One sub-module: rr_arbiter (req vector, rr pointer, one-hot grant, grant index); tag pipeline and response register stay in top.

## Test plan
- Single request: req 2 valid 100/7 at T -> req_ready[2] at T, rsp_valid=0100b, rsp_quotient=14 at T+67 (default latency), busy low after.
- All four requesting continuously from rr=0 -> grants 0,1,2,3,0,... one per cycle; responses return in the same order 67 cycles later, each one cycle.
- Req 1 and 3 valid, rr=2 -> grant 3 first, then 1; rr ends at 2.
- With DIV_ZERO_CHECK_EN: 55/0 from req 0 -> rsp_quotient all ones, rsp_dbz=1; 55/5 next cycle -> 11, rsp_dbz=0. Without: rsp_dbz stays 0.
- Issue 10 divides, assert rstn=0 for one cycle at 30 cycles in -> all outputs reset values next cycle; no rsp_valid for any pre-reset issue; new request after reset returns correct quotient.
- Self-check: random operands/requester mix, 10k cycles, scoreboard per requester for ordering, value and no dropped/duplicated responses.
